// File: rtl/arbitro_rx_lanes_if.sv
// Lane-FIFO side and downstream side of the RX lane scheduler, bundled as one bus.
// The scheduler is the master; whoever owns the FIFOs and the consumer is the slave.
interface arbitro_rx_lanes_if #(
  parameter int DATA_W = 8
);
  logic              empty0;
  logic              empty1;
  logic              empty2;
  logic              empty3;
  logic [DATA_W-1:0] data_fifo0;
  logic [DATA_W-1:0] data_fifo1;
  logic [DATA_W-1:0] data_fifo2;
  logic [DATA_W-1:0] data_fifo3;
  logic              almost_full_out;
  logic              pop0;
  logic              pop1;
  logic              pop2;
  logic              pop3;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [1:0]        lane_out;
  logic              active;

  modport master (
    input  empty0, empty1, empty2, empty3,
    input  data_fifo0, data_fifo1, data_fifo2, data_fifo3,
    input  almost_full_out,
    output pop0, pop1, pop2, pop3,
    output data_out, valid_out, lane_out, active
  );

  modport slave (
    output empty0, empty1, empty2, empty3,
    output data_fifo0, data_fifo1, data_fifo2, data_fifo3,
    output almost_full_out,
    input  pop0, pop1, pop2, pop3,
    input  data_out, valid_out, lane_out, active
  );
endinterface

// File: rtl/arbitro_rx_lanes.sv
// Round-robin scheduler draining four RX lane FIFOs onto one tagged output bus,
// with a per-lane burst limit, back-pressure stall and a fixed two-cycle latency.
module arbitro_rx_lanes #(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input logic                clk_4f,
  input logic                reset,
  arbitro_rx_lanes_if.master bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [3:0] BURST_L = 4'(BURST);

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        cur;
  logic [3:0]        burst_cnt;
  logic [1:0]        ptr_n;
  logic [1:0]        cur_n;
  logic [3:0]        burst_n;
  logic [3:0]        run_len;
  logic [3:0]        req;
  logic [3:0]        req_rot;
  logic [3:0]        grant;
  logic [1:0]        grant_lane;
  logic              can_issue;
  logic [DATA_W-1:0] lane_data [4];

  logic              vld_p0;
  logic [1:0]        lane_p0;
  logic              vld_p1;
  logic [1:0]        lane_p1;
  logic [DATA_W-1:0] data_p1;
  logic              active_p1;

  function automatic logic [1:0] first_req(input logic [3:0] v);
    first_req = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (v[k]) first_req = 2'(k);
    end
  endfunction

  assign req          = ~{bus.empty3, bus.empty2, bus.empty1, bus.empty0};
  assign lane_data[0] = bus.data_fifo0;
  assign lane_data[1] = bus.data_fifo1;
  assign lane_data[2] = bus.data_fifo2;
  assign lane_data[3] = bus.data_fifo3;

  // reset gates the pops combinationally, so nothing leaves a FIFO while held
  assign can_issue = reset & ~bus.almost_full_out & (|req);

  // bit k of req_rot is lane ptr+k, so the lowest set bit is the round-robin winner
  always_comb begin
    case (ptr)
      2'd0:    req_rot = req;
      2'd1:    req_rot = {req[0],   req[3:1]};
      2'd2:    req_rot = {req[1:0], req[3:2]};
      default: req_rot = {req[2:0], req[3]};
    endcase
  end

  always_comb begin
    grant_lane = cur;
    if (!(req[cur] && burst_cnt != 4'd0)) grant_lane = ptr + first_req(req_rot);
    grant = can_issue ? (4'b0001 << grant_lane) : 4'b0000;
  end

  assign bus.pop0 = grant[0];
  assign bus.pop1 = grant[1];
  assign bus.pop2 = grant[2];
  assign bus.pop3 = grant[3];

  // a stall leaves ptr/cur/burst_cnt alone so the interrupted burst resumes afterwards
  always_comb begin
    ptr_n   = ptr;
    cur_n   = cur;
    burst_n = burst_cnt;
    run_len = (grant_lane == cur) ? burst_cnt + 4'd1 : 4'd1;
    if (can_issue) begin
      cur_n = grant_lane;
      if (run_len >= BURST_L) begin
        ptr_n   = grant_lane + 2'd1;
        burst_n = 4'd0;
      end else begin
        burst_n = run_len;
        if (grant_lane != cur && burst_cnt != 4'd0) ptr_n = cur + 2'd1;
      end
    end else if (!bus.almost_full_out && burst_cnt != 4'd0) begin
      ptr_n   = cur + 2'd1;
      burst_n = 4'd0;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state     <= IDLE;
      active_p1 <= 1'b0;
      ptr       <= 2'd0;
      cur       <= 2'd0;
      burst_cnt <= 4'd0;
      vld_p0    <= 1'b0;
      lane_p0   <= 2'd0;
      vld_p1    <= 1'b0;
      lane_p1   <= 2'd0;
      data_p1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_issue) begin
            state     <= ACTIVE;
            active_p1 <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!can_issue) begin
            state     <= IDLE;
            active_p1 <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          active_p1 <= 1'b0;
        end
      endcase
      ptr       <= ptr_n;
      cur       <= cur_n;
      burst_cnt <= burst_n;
      // stage p0: lane tag of the word the FIFO presents during the next cycle
      vld_p0    <= can_issue;
      lane_p0   <= grant_lane;
      // stage p1: capture the popped word; data/lane hold when no word arrives
      vld_p1    <= vld_p0;
      if (vld_p0) begin
        data_p1 <= lane_data[lane_p0];
        lane_p1 <= lane_p0;
      end
    end
  end

  assign bus.data_out  = data_p1;
  assign bus.valid_out = vld_p1;
  assign bus.lane_out  = lane_p1;
  assign bus.active    = active_p1;

endmodule

// File: tb/tb_arbitro_rx_lanes.sv
// Bench for arbitro_rx_lanes: directed scenarios plus random traffic, each cycle
// compared against a queue-based reference of the scheduling rules.
module tb_arbitro_rx_lanes;

  localparam int DATA_W = 8;
  localparam int BURST  = 4;

  typedef struct {
    int         due;
    int         lane;
    logic [7:0] data;
  } ev_t;

  logic clk_4f = 1'b0;
  logic reset  = 1'b0;
  logic afo    = 1'b0;

  always #5 clk_4f = ~clk_4f;

  arbitro_rx_lanes_if #(.DATA_W(DATA_W)) bus ();

  arbitro_rx_lanes #(.DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  int         checks;
  int         errors;
  int         cyc;
  logic [7:0] fq [4][$];
  logic [7:0] frd [4];
  ev_t        expq [$];
  logic [7:0] last_data;
  logic [1:0] last_lane;
  logic       exp_active;
  int         m_ptr;
  int         m_cur;
  int         m_cnt;
  int         vlane [$];
  logic [7:0] vdata [$];
  int         vcyc  [$];
  int         elane [$];
  logic [7:0] edata [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.empty0          = (fq[0].size() == 0);
    bus.empty1          = (fq[1].size() == 0);
    bus.empty2          = (fq[2].size() == 0);
    bus.empty3          = (fq[3].size() == 0);
    bus.data_fifo0      = frd[0];
    bus.data_fifo1      = frd[1];
    bus.data_fifo2      = frd[2];
    bus.data_fifo3      = frd[3];
    bus.almost_full_out = afo;
  endtask

  task automatic push(input int l, input logic [7:0] d);
    fq[l].push_back(d);
  endtask

  task automatic expect_word(input int l, input logic [7:0] d);
    elane.push_back(l);
    edata.push_back(d);
  endtask

  task automatic clear_log();
    vlane.delete();
    vdata.delete();
    vcyc.delete();
    elane.delete();
    edata.delete();
  endtask

  // Which lane the rules say gets popped now, or -1 for none.
  function automatic int ref_grant();
    if (!reset || afo) return -1;
    if (m_cnt > 0 && fq[m_cur].size() > 0) return m_cur;
    for (int k = 0; k < 4; k++) begin
      if (fq[(m_ptr + k) % 4].size() > 0) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    int         g;
    int         run;
    logic [3:0] exp_pop;
    logic [3:0] dut_pop;
    logic       exp_valid;
    ev_t        ev;
    drive();
    @(negedge clk_4f);
    g       = ref_grant();
    exp_pop = (g >= 0) ? 4'(1 << g) : 4'd0;
    dut_pop = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    check("pop", 32'(dut_pop), 32'(exp_pop));
    exp_valid = 1'b0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      ev        = expq.pop_front();
      exp_valid = 1'b1;
      last_data = ev.data;
      last_lane = 2'(ev.lane);
    end
    check("valid_out", 32'(bus.valid_out), 32'(exp_valid));
    check("data_out", 32'(bus.data_out), 32'(last_data));
    check("lane_out", 32'(bus.lane_out), 32'(last_lane));
    check("active", 32'(bus.active), 32'(exp_active));
    if (bus.valid_out === 1'b1) begin
      vlane.push_back(int'(bus.lane_out));
      vdata.push_back(bus.data_out);
      vcyc.push_back(cyc);
    end
    if (!reset) begin
      expq.delete();
      last_data  = 8'h00;
      last_lane  = 2'd0;
      exp_active = 1'b0;
      m_ptr      = 0;
      m_cur      = 0;
      m_cnt      = 0;
    end else begin
      exp_active = (g >= 0);
      if (g >= 0) begin
        expq.push_back('{cyc + 2, g, fq[g][0]});
        run = (g == m_cur) ? m_cnt + 1 : 1;
        if (g != m_cur && m_cnt > 0) m_ptr = (m_cur + 1) % 4;
        m_cur = g;
        if (run >= BURST) begin
          m_ptr = (g + 1) % 4;
          m_cnt = 0;
        end else begin
          m_cnt = run;
        end
      end else if (!afo && m_cnt > 0) begin
        m_ptr = (m_cur + 1) % 4;
        m_cnt = 0;
      end
    end
    @(posedge clk_4f);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (dut_pop[i] === 1'b1 && fq[i].size() > 0) frd[i] = fq[i].pop_front();
    end
    cyc++;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, 32'(vlane.size()), 32'(elane.size()));
    for (int i = 0; i < elane.size() && i < vlane.size(); i++) begin
      check($sformatf("%s_lane%0d", tag, i), 32'(vlane[i]), 32'(elane[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(vdata[i]), 32'(edata[i]));
    end
  endtask

  initial begin
    int rel;
    int n0;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    last_data  = 8'h00;
    last_lane  = 2'd0;
    exp_active = 1'b0;
    m_ptr      = 0;
    m_cur      = 0;
    m_cnt      = 0;
    for (int i = 0; i < 4; i++) frd[i] = 8'($urandom);
    drive();
    repeat (2) @(posedge clk_4f);
    #1;

    // Reset held with every lane loaded, then strict round-robin drain
    clear_log();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 6; k++) push(l, 8'(16 * l + k));
    repeat (3) tick();
    reset = 1'b1;
    rel   = cyc;
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++)
        for (int j = 0; j < (r == 0 ? 4 : 2); j++) expect_word(l, 8'(16 * l + 4 * r + j));
    repeat (32) tick();
    check_log("fair");
    if (vcyc.size() > 0) begin
      check("fair_first_valid", 32'(vcyc[0] - rel), 32'd2);
      check("fair_span", 32'(vcyc[vcyc.size() - 1] - vcyc[0]), 32'd23);
    end

    // Single lane with three words
    clear_log();
    push(2, 8'hA1);
    push(2, 8'hA2);
    push(2, 8'hA3);
    for (int j = 1; j <= 3; j++) expect_word(2, 8'(8'hA0 + j));
    repeat (7) tick();
    check_log("single");

    // Back-pressure after two pops of lane1; its burst resumes after the stall
    clear_log();
    for (int j = 0; j < 6; j++) push(1, 8'(8'hB0 + j));
    push(2, 8'hC0);
    push(2, 8'hC1);
    for (int j = 0; j < 4; j++) expect_word(1, 8'(8'hB0 + j));
    expect_word(2, 8'hC0);
    expect_word(2, 8'hC1);
    expect_word(1, 8'hB4);
    expect_word(1, 8'hB5);
    repeat (2) tick();
    afo = 1'b1;
    n0  = vlane.size();
    repeat (5) tick();
    check("bp_inflight", 32'(vlane.size() - n0), 32'd2);
    afo = 1'b0;
    repeat (14) tick();
    check_log("bp");

    // Pointer wrap: lane2 primes ptr to 3, then lanes 3 and 0 only
    clear_log();
    push(2, 8'hD0);
    repeat (4) tick();
    push(3, 8'hE0);
    push(3, 8'hE1);
    push(0, 8'hF0);
    push(0, 8'hF1);
    expect_word(2, 8'hD0);
    expect_word(3, 8'hE0);
    expect_word(3, 8'hE1);
    expect_word(0, 8'hF0);
    expect_word(0, 8'hF1);
    repeat (10) tick();
    check_log("wrap");

    // Reset one cycle after a pop discards the in-flight word
    clear_log();
    push(0, 8'h51);
    push(0, 8'h52);
    push(0, 8'h53);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    expect_word(0, 8'h52);
    expect_word(0, 8'h53);
    repeat (8) tick();
    check_log("midreset");

    // Random traffic, stalls and occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int l = 0; l < 4; l++)
        if ($urandom_range(0, 99) < 18) push(l, 8'($urandom));
      afo   = ($urandom_range(0, 99) < 15);
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end
    afo   = 1'b0;
    reset = 1'b1;
    for (int n = 0; n < 400 && (fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()) > 0; n++) tick();
    repeat (4) tick();
    check("drained_valid", 32'(bus.valid_out), 32'd0);
    check("drained_active", 32'(bus.active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_rx_lanes.md
Name: arbitro_rx_lanes

Overview:
- Round-robin scheduler that drains the four RX lane FIFOs onto one shared 8-bit output bus.
- Sits after the RX lane demux and the per-lane FIFOs, and feeds the downstream consumer.
- Issues at most one pop per cycle, tags each word with its lane, limits consecutive pops per lane, and stalls on downstream back-pressure.

Parameters:
DATA_W, 8, width of lane words and data_out
BURST, 4, max consecutive pops granted to one lane before rotating (1..15)

Ports:
clk_4f  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
empty0..empty3  input  1 each  lane FIFO empty flags, registered in FIFO, reflect pops of previous edges
data_fifo0..data_fifo3  input  DATA_W each  lane FIFO read data, valid the cycle after the corresponding pop
almost_full_out  input  1  downstream back-pressure; 1 = issue no new pops
pop0..pop3  output  1 each  FIFO read strobes, one-hot or zero
data_out  output  DATA_W  arbitrated word
valid_out  output  1  data_out/lane_out valid this cycle
lane_out  output  2  source lane of data_out
active  output  1  1 while state = ACTIVE

Behaviour:
- Reset (reset=0 at edge):
  - ptr=0, burst_cnt=0, state=IDLE, pipeline regs cleared.
  - data_out=0, valid_out=0, lane_out=0, active=0.
  - pop0..3 forced 0 combinationally while reset=0.
  - Reset mid-operation discards all in-flight words; nothing is emitted afterwards for them.
- req[i] = ~empty_i.
- can_issue = reset & ~almost_full_out & |req.
- States (registered):
  - IDLE: no pops issued. -> ACTIVE when can_issue.
  - ACTIVE: one pop per cycle while can_issue. -> IDLE when ~can_issue (no req, or almost_full_out=1).
- Pops are combinational from registered ptr/cur/burst_cnt plus current empty/almost_full_out. They issue in the first cycle can_issue holds; no wait for the state register.
- Grant selection each cycle with can_issue:
  - If cur has req and burst_cnt < BURST, grant cur (burst continues).
  - Otherwise grant the first requesting lane scanning ptr, ptr+1, ... mod 4.
- Grant update at edge:
  - On pop of lane g: if g == cur, burst_cnt++; else cur=g, burst_cnt=1.
  - When burst_cnt reaches BURST, or lane cur is not popped in a cycle, ptr = cur+1 mod 4 and burst_cnt=0.
  - Lane g is never popped when empty_g=1.
- Pipeline, fixed latency 2:
  - Pop of lane g in cycle t -> stage1 records g in t+1 while data_fifo_g is valid.
  - At the end of t+1, data_fifo_g is registered into data_out, lane_out=g, valid_out=1, all visible in cycle t+2.
  - Back-to-back pops give back-to-back valid_out with no bubbles.
  - valid_out=0 in cycles with no pop two cycles earlier; data_out and lane_out hold their last values.
- Back-pressure:
  - almost_full_out=1 stops new pops in that same cycle.
  - Up to 2 in-flight words still emerge; the downstream must reserve ≥2 slots.
  - almost_full_out=1 leaves ptr, cur and burst_cnt unchanged, so the burst resumes after the stall.
- Simultaneous events:
  - All lanes requesting: order is strictly round-robin with up to BURST words per lane.
  - Lane goes empty mid-burst: rotate next cycle with no lost cycle if another lane requests.
- Width: burst_cnt 4 bits, no wrap past BURST. ptr/cur 2 bits, modulo-4 wrap from 3 to 0.

Test Plan:
- Reset hold: reset=0 for 3 cycles with all lanes non-empty -> pops=0, valid_out=0, data_out=0, active=0; after release, first pop0 on the next cycle and first valid_out 2 cycles later.
- Single lane: lane2 holds 0xA1,0xA2,0xA3, others empty, BURST=4 -> pop2 for 3 consecutive cycles, data_out A1,A2,A3 on consecutive cycles, lane_out=2, then IDLE.
- Fairness: all four lanes hold 6 words, BURST=4 -> lane order 0×4,1×4,2×4,3×4,0×2,1×2,2×2,3×2; 24 valid_out pulses, no bubbles.
- Back-pressure: almost_full_out=1 for 5 cycles mid-burst after 2 pops of lane1 -> pops stop immediately, exactly the 2 in-flight words still appear, and lane1 resumes for its remaining 2-word burst.
- Wrap: only lanes 3 and 0 non-empty, ptr=3 -> grants lane3 then lane0, ptr wraps 3->0->1, no pop to empty lanes.
- Mid-operation reset: reset=0 one cycle after pop0 -> the in-flight word never appears, and all outputs are 0 on the next cycle.
